// File: rtl/imem_load_ctrl.sv
// Boot/program-load controller: copies the program ROM into instruction memory
// while holding the CPU in reset, and shares the imem write port with a debug requester.
module imem_load_ctrl #(
  parameter int          PROG_WORDS = 45,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic [31:0] src_index,
  input  logic [31:0] src_data,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_data,
  output logic        dbg_gnt,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2,
    RUN    = 2'd3
  } state_t;

  localparam logic [31:0] LAST_IDX = 32'(PROG_WORDS - 1);

  state_t      state_q, state_d;
  logic [31:0] idx_q, idx_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        gnt_q, gnt_d;
  logic        done_q, done_d;
  logic        boot_q, boot_d;
  logic        start_eff;
  logic        dbg_ok;

  // Debug handshake: a request is taken only in IDLE/RUN, never while start is
  // asserted, and never in the cycle right after a grant (the requester drops
  // dbg_req when it sees dbg_gnt, so a still-high request then is a new one).
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    gnt_d     = 1'b0;
    done_d    = 1'b0;
    boot_d    = 1'b0;
    // boot_q is only set for the first edge after reset release
    start_eff = start | (AUTO_START & boot_q);
    dbg_ok    = dbg_req & ~gnt_q;

    case (state_q)
      IDLE, RUN: begin
        if (start_eff) begin
          state_d = LOAD;
          idx_d   = 32'd0;
        end else if (dbg_ok) begin
          we_d    = 1'b1;
          addr_d  = dbg_addr;
          wdata_d = dbg_data;
          gnt_d   = 1'b1;
        end
      end
      LOAD: begin
        we_d    = 1'b1;
        addr_d  = BASE_ADDR + (idx_q << 2);
        wdata_d = src_data;
        if (idx_q == LAST_IDX) begin
          state_d = FINISH;
        end else begin
          idx_d = idx_q + 32'd1;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= 32'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      gnt_q   <= 1'b0;
      done_q  <= 1'b0;
      boot_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      boot_q  <= boot_d;
    end
  end

  // The CPU comes out of reset at the same edge the final write commits.
  assign cpu_hold   = (state_q != RUN);
  assign busy       = (state_q == LOAD) || (state_q == FINISH);
  assign src_index  = idx_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign dbg_gnt    = gnt_q;
  assign done       = done_q;
  assign state_dbg  = state_q;

endmodule
